// File: rtl/netid_pkg.sv
// rtl/netid_pkg.sv - shared state encoding and default NetID constants for the sequence reader.
package netid_pkg;

    localparam int         NETID_DEPTH = 4;
    localparam logic [7:0] NETID_SYM   = 8'h7D;

    typedef enum logic [1:0] {
        LOAD,
        HUNT,
        TRACK,
        HIT
    } state_t;

endpackage

// File: rtl/netid_sym_cmp.sv
// rtl/netid_sym_cmp.sv - compares one symbol against one pattern slot (masked when NETID_SEQ_MASK_EN).
module netid_sym_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sym,
    input  logic [WIDTH-1:0] slot,
`ifdef NETID_SEQ_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             eq
);

`ifdef NETID_SEQ_MASK_EN
    // A cleared mask bit makes that bit position a don't-care.
    assign eq = ((sym ^ slot) & mask) == '0;
`else
    assign eq = (sym == slot);
`endif

endmodule

// File: rtl/netid_seq_reader.sv
// rtl/netid_seq_reader.sv - streaming NetID pattern detector with run-time reprogramming.
// Optional per-bit don't-care masks are enabled by defining NETID_SEQ_MASK_EN.
module netid_seq_reader
    import netid_pkg::*;
#(
    parameter int                     WIDTH        = 8,
    parameter int                     DEPTH        = NETID_DEPTH,
    parameter logic [WIDTH*DEPTH-1:0] INIT_PATTERN = {DEPTH{WIDTH'(NETID_SYM)}},
    parameter int                     CNT_W        = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sym_valid,
    input  logic [WIDTH-1:0]         sym,
    input  logic                     prog_en,
    input  logic [WIDTH-1:0]         prog_sym,
`ifdef NETID_SEQ_MASK_EN
    input  logic [WIDTH-1:0]         prog_mask,
`endif
    output logic                     match,
    output logic [$clog2(DEPTH)-1:0] progress,
    output logic                     busy_prog,
    output logic [CNT_W-1:0]         match_cnt
);

    localparam int           PW   = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    state_t           state;
    logic [PW-1:0]    prog_idx;
    logic [WIDTH-1:0] pattern [DEPTH];
    logic             hit_cur;
    logic             hit_first;

`ifdef NETID_SEQ_MASK_EN
    logic [WIDTH-1:0] mask [DEPTH];

    netid_sym_cmp #(.WIDTH(WIDTH)) u_cmp_cur (
        .sym  (sym),
        .slot (pattern[progress]),
        .mask (mask[progress]),
        .eq   (hit_cur)
    );

    netid_sym_cmp #(.WIDTH(WIDTH)) u_cmp_first (
        .sym  (sym),
        .slot (pattern[0]),
        .mask (mask[0]),
        .eq   (hit_first)
    );
`else
    netid_sym_cmp #(.WIDTH(WIDTH)) u_cmp_cur (
        .sym  (sym),
        .slot (pattern[progress]),
        .eq   (hit_cur)
    );

    netid_sym_cmp #(.WIDTH(WIDTH)) u_cmp_first (
        .sym  (sym),
        .slot (pattern[0]),
        .eq   (hit_first)
    );
`endif

    // progress is held at 0 in HIT, so pattern[progress] already restarts from slot 0 there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pattern[i] <= INIT_PATTERN[i*WIDTH +: WIDTH];
`ifdef NETID_SEQ_MASK_EN
                mask[i]    <= '1;
`endif
            end
            prog_idx  <= '0;
            state     <= HUNT;
            progress  <= '0;
            match     <= 1'b0;
            busy_prog <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= 1'b0;
            if (prog_en) begin
                pattern[prog_idx] <= prog_sym;
`ifdef NETID_SEQ_MASK_EN
                mask[prog_idx]    <= prog_mask;
`endif
                progress <= '0;
                if (prog_idx == LAST) begin
                    prog_idx  <= '0;
                    busy_prog <= 1'b0;
                    state     <= HUNT;
                end else begin
                    prog_idx  <= prog_idx + 1'b1;
                    busy_prog <= 1'b1;
                    state     <= LOAD;
                end
            end else if (state != LOAD) begin
                if (sym_valid) begin
                    if (hit_cur && progress == LAST) begin
                        state    <= HIT;
                        match    <= 1'b1;
                        progress <= '0;
                        if (match_cnt != '1) begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end else if (hit_cur) begin
                        state    <= TRACK;
                        progress <= progress + 1'b1;
                    end else if (hit_first) begin
                        state    <= TRACK;
                        progress <= PW'(1);
                    end else begin
                        state    <= HUNT;
                        progress <= '0;
                    end
                end else if (state == HIT) begin
                    state <= HUNT;
                end
            end
        end
    end

endmodule
